decode_stage: RTL and testbench

Second pipeline stage: consumes the 32-bit two-word window from the fetch stage, identifies 16-bit and 32-bit instructions, and issues one registered decoded instruction per cycle to execute through a valid/ready handshake. It decodes control flow locally and drives fetch's jump request, jump operands, flush and run-enable inputs. It holds the jump request for a fixed number of cycles so that fetch can redirect and refill.

---
 rtl/decode_stage.sv | 217 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decodes the fetch window into one registered bundle per cycle (1-cycle latency); fetch stalls while dec_valid_o is held without ex_ready_i.
// Control flow redirects fetch locally for JUMP_HOLD cycles; `define DECODE_32BIT_EN enables 32-bit decode and the SKIP state.
module decode_stage #(
    parameter int JUMP_HOLD = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [31:0] fetchoutput_i,
    input  logic [19:0] previous_programcounter_i,
    input  logic        ex_ready_i,
    output logic        fetch_enable_o,
    output logic [2:0]  pcjumpenable_o,
    output logic [8:0]  pcchange_o,
    output logic [5:0]  pclocation_o,
    output logic        flush_o,
    output logic        dec_valid_o,
    output logic [1:0]  dec_class_o,
    output logic [3:0]  dec_op_o,
    output logic [5:0]  dec_rd_o,
    output logic [5:0]  dec_ra_o,
    output logic [5:0]  dec_rb_o,
    output logic [15:0] dec_imm_o,
    output logic        dec_len32_o,
    output logic        dec_link_o,
    output logic [19:0] dec_pc_o,
    output logic        illegal_o
);
    localparam int CW = $clog2(JUMP_HOLD + 1);

    typedef enum logic [1:0] {RUN, SKIP, HOLD} state_t;

    typedef struct packed {
        logic [1:0]  cls;
        logic [3:0]  op;
        logic [5:0]  rd;
        logic [5:0]  ra;
        logic [5:0]  rb;
        logic [15:0] imm;
        logic        len32;
        logic        link;
        logic [19:0] pc;
    } dec_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dec_t          dec_q, dec_d, issue;
    logic          dec_valid_q, dec_valid_d;
    logic [2:0]    pcjumpenable_q, pcjumpenable_d;
    logic [8:0]    pcchange_q, pcchange_d;
    logic [5:0]    pclocation_q, pclocation_d;
    logic          flush_q, flush_d;
    logic          illegal_q, illegal_d;

    logic [15:0] w1, w2;
    logic        stall, bubble, is_long, long_ok, is_illegal, is_cf, is_link;
    logic [2:0]  cf_code;

    assign w1 = fetchoutput_i[31:16];
    assign w2 = fetchoutput_i[15:0];

    assign stall      = dec_valid_q & ~ex_ready_i;
    assign bubble     = (w1[15:1] == 15'd0);
    assign is_long    = w1[15];
    assign is_cf      = ~w1[15] & (w1[14:13] == 2'd2) & (w1[12:11] == 2'd0);
    assign is_link    = is_cf & w1[10];
    assign cf_code    = {1'b0, w1[10:9]} + 3'd1;
    assign is_illegal = is_long & ~long_ok;

`ifdef DECODE_32BIT_EN
    logic unused_w2;
    assign long_ok   = is_long & w2[15];
    assign unused_w2 = ^w2[14:13];
`else
    logic unused_w2;
    assign long_ok   = 1'b0;
    assign unused_w2 = ^w2;
`endif

    always_comb begin
        issue       = '0;
        issue.cls   = w1[14:13];
        issue.op    = w1[12:9];
        issue.rd    = {3'b000, w1[8:6]};
        issue.ra    = {3'b000, w1[5:3]};
        issue.rb    = {3'b000, w1[2:0]};
        issue.imm   = (w1[14:13] == 2'd2) ? {{7{w1[8]}}, w1[8:0]} : {13'd0, w1[2:0]};
        issue.link  = is_link;
        issue.pc    = previous_programcounter_i;
`ifdef DECODE_32BIT_EN
        if (long_ok) begin
            issue.rd    = {w2[8:6], w1[8:6]};
            issue.ra    = {w2[5:3], w1[5:3]};
            issue.rb    = {w2[2:0], w1[2:0]};
            issue.imm   = {w2[12:0], w1[2:0]};
            issue.len32 = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // HOLD counts down even under backpressure so the jump request lasts exactly JUMP_HOLD cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (!stall && !bubble && !is_illegal) begin
                    if (is_cf) begin
                        state_d = HOLD;
                        cnt_d   = CW'(JUMP_HOLD);
                    end else if (long_ok) begin
                        state_d = SKIP;
                    end
                end
            end
            SKIP: begin
                if (!stall) state_d = RUN;
            end
            HOLD: begin
                if (cnt_q == CW'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        dec_d          = dec_q;
        dec_valid_d    = stall;
        pcjumpenable_d = pcjumpenable_q;
        pcchange_d     = pcchange_q;
        pclocation_d   = pclocation_q;
        flush_d        = flush_q;
        illegal_d      = 1'b0;
        case (state_q)
            RUN: begin
                if (!stall && !bubble) begin
                    if (is_illegal) begin
                        illegal_d = 1'b1;
                    end else if (is_cf) begin
                        pcjumpenable_d = cf_code;
                        pcchange_d     = w1[8:0];
                        pclocation_d   = w1[5:0];
                        flush_d        = 1'b1;
                        if (is_link) begin
                            dec_valid_d = 1'b1;
                            dec_d       = issue;
                        end
                    end else begin
                        dec_valid_d = 1'b1;
                        dec_d       = issue;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == CW'(1)) begin
                    pcjumpenable_d = 3'd0;
                    flush_d        = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            dec_q          <= '0;
            dec_valid_q    <= 1'b0;
            pcjumpenable_q <= 3'd0;
            pcchange_q     <= 9'd0;
            pclocation_q   <= 6'd0;
            flush_q        <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            dec_q          <= dec_d;
            dec_valid_q    <= dec_valid_d;
            pcjumpenable_q <= pcjumpenable_d;
            pcchange_q     <= pcchange_d;
            pclocation_q   <= pclocation_d;
            flush_q        <= flush_d;
            illegal_q      <= illegal_d;
        end
    end

    assign fetch_enable_o = ~stall;
    assign pcjumpenable_o = pcjumpenable_q;
    assign pcchange_o     = pcchange_q;
    assign pclocation_o   = pclocation_q;
    assign flush_o        = flush_q;
    assign dec_valid_o    = dec_valid_q;
    assign dec_class_o    = dec_q.cls;
    assign dec_op_o       = dec_q.op;
    assign dec_rd_o       = dec_q.rd;
    assign dec_ra_o       = dec_q.ra;
    assign dec_rb_o       = dec_q.rb;
    assign dec_imm_o      = dec_q.imm;
    assign dec_len32_o    = dec_q.len32;
    assign dec_link_o     = dec_q.link;
    assign dec_pc_o       = dec_q.pc;
    assign illegal_o      = illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: expected bundles queued at drive time, popped on each handshake; per-scenario inline checks.
module tb_decode_stage;
    localparam int JH = 2;

    typedef struct packed {
        logic [1:0]  cls;
        logic [3:0]  op;
        logic [5:0]  rd;
        logic [5:0]  ra;
        logic [5:0]  rb;
        logic [15:0] imm;
        logic        len32;
        logic        link;
        logic [19:0] pc;
    } bundle_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] fetchoutput;
    logic [19:0] prev_pc;
    logic        ex_ready;
    logic        fetch_enable, flush, dec_valid, dec_len32, dec_link, illegal;
    logic [2:0]  pje;
    logic [8:0]  pcchange;
    logic [5:0]  pclocation, dec_rd, dec_ra, dec_rb;
    logic [1:0]  dec_class;
    logic [3:0]  dec_op;
    logic [15:0] dec_imm;
    logic [19:0] dec_pc;

    bundle_t exp_q[$];
    bundle_t got, mon_exp;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage #(.JUMP_HOLD(JH)) dut (
        .clock_i(clk), .reset_i(reset_n), .fetchoutput_i(fetchoutput),
        .previous_programcounter_i(prev_pc), .ex_ready_i(ex_ready),
        .fetch_enable_o(fetch_enable), .pcjumpenable_o(pje), .pcchange_o(pcchange),
        .pclocation_o(pclocation), .flush_o(flush), .dec_valid_o(dec_valid),
        .dec_class_o(dec_class), .dec_op_o(dec_op), .dec_rd_o(dec_rd), .dec_ra_o(dec_ra),
        .dec_rb_o(dec_rb), .dec_imm_o(dec_imm), .dec_len32_o(dec_len32),
        .dec_link_o(dec_link), .dec_pc_o(dec_pc), .illegal_o(illegal)
    );

    assign got = {dec_class, dec_op, dec_rd, dec_ra, dec_rb, dec_imm, dec_len32, dec_link, dec_pc};

    function automatic bundle_t model(input logic [31:0] win, input logic [19:0] pc);
        logic [15:0] a, b;
        bundle_t r;
        a = win[31:16];
        b = win[15:0];
        r = '0;
        r.cls = a[14:13];
        r.op  = a[12:9];
        r.pc  = pc;
        if (a[15]) begin
            r.rd = {b[8:6], a[8:6]};
            r.ra = {b[5:3], a[5:3]};
            r.rb = {b[2:0], a[2:0]};
            r.imm = {b[12:0], a[2:0]};
            r.len32 = 1'b1;
        end else begin
            r.rd = {3'b000, a[8:6]};
            r.ra = {3'b000, a[5:3]};
            r.rb = {3'b000, a[2:0]};
            r.imm = (a[14:13] == 2'd2) ? {{7{a[8]}}, a[8:0]} : {13'd0, a[2:0]};
            r.link = (a[14:13] == 2'd2) && (a[12:9] == 4'd2 || a[12:9] == 4'd3);
        end
        return r;
    endfunction

    // Handshake happens at the next posedge; compare the bundle half a cycle before it.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && dec_valid === 1'b1 && ex_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_issue: got %h, expected no issue", got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL bundle: got %h, expected %h", got, mon_exp);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ex_ready = 1'b1; prev_pc = 20'h0; fetchoutput = 32'h1234_5678;
        tick(3);
        n_checks++;
        if ({pje, pcchange, pclocation, flush, dec_valid, got, illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0", {pje, pcchange, pclocation, flush, dec_valid, got, illegal});
        end
        n_checks++;
        if (fetch_enable !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_enable: got %b, expected 1", fetch_enable); end
        fetchoutput = 32'h0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: dec_valid got %b, expected 0", dec_valid); end
        end
    endtask

    task automatic test_bubbles();
        logic [31:0] words [2];
        words[0] = 32'h0001_ABCD;
        words[1] = 32'h0000_FFFF;
        for (int i = 0; i < 2; i++) begin
            fetchoutput = words[i];
            tick();
            n_checks++;
            if ({dec_valid, illegal} !== 2'b00) begin
                n_fail++;
                $display("FAIL bubble_%0d: valid/illegal got %b, expected 00", i, {dec_valid, illegal});
            end
        end
        fetchoutput = 32'h0;
        tick();
    endtask

    task automatic test_alu();
        prev_pc = 20'h12345;
        fetchoutput = 32'h0A5B_0000;
        exp_q.push_back(model(fetchoutput, prev_pc));
        tick();
        n_checks++;
        if ({dec_valid, dec_op, dec_rd, dec_ra, dec_rb} !== {1'b1, 4'd5, 6'd1, 6'd3, 6'd3}) begin
            n_fail++;
            $display("FAIL alu_fields: got v%b op%0d rd%0d ra%0d rb%0d, expected v1 op5 rd1 ra3 rb3",
                     dec_valid, dec_op, dec_rd, dec_ra, dec_rb);
        end
        fetchoutput = 32'h0;
        tick();
        n_checks++;
        if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL alu_drop: dec_valid got %b, expected 0", dec_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        words[0] = 32'h0A5B_0000;
        words[1] = 32'h4FC5_0000;
        words[2] = 32'h1C2D_0000;
        for (int i = 0; i < 3; i++) begin
            prev_pc = 20'h00100 + 20'(i);
            fetchoutput = words[i];
            exp_q.push_back(model(words[i], prev_pc));
            tick();
            n_checks++;
            if ({dec_valid, pje} !== {1'b1, 3'd0}) begin
                n_fail++;
                $display("FAIL b2b_%0d: valid/pje got %b/%0d, expected 1/0", i, dec_valid, pje);
            end
        end
        n_checks++;
        if (dec_imm !== 16'h0005) begin n_fail++; $display("FAIL b2b_last_imm: got %h, expected 0005", dec_imm); end
        fetchoutput = 32'h0;
        tick();
    endtask

    task automatic test_control_flow();
        logic [15:0] words [4];
        logic [2:0]  codes [4];
        logic [8:0]  offs [4];
        logic [5:0]  tgts [4];
        logic        links [4];
        words[0] = 16'h4005; codes[0] = 3'd1; offs[0] = 9'h005; tgts[0] = 6'h05; links[0] = 1'b0;
        words[1] = 16'h4217; codes[1] = 3'd2; offs[1] = 9'h017; tgts[1] = 6'h17; links[1] = 1'b0;
        words[2] = 16'h4423; codes[2] = 3'd3; offs[2] = 9'h023; tgts[2] = 6'h23; links[2] = 1'b1;
        words[3] = 16'h47F0; codes[3] = 3'd4; offs[3] = 9'h1F0; tgts[3] = 6'h30; links[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            prev_pc = 20'hA0000 + 20'(i);
            fetchoutput = {words[i], 16'h0000};
            if (links[i]) exp_q.push_back(model(fetchoutput, prev_pc));
            tick();
            n_checks++;
            if ({dec_valid, dec_link} !== {links[i], links[i]}) begin
                n_fail++;
                $display("FAIL cf_issue_%0d: valid/link got %b%b, expected %b%b", i, dec_valid, dec_link, links[i], links[i]);
            end
            for (int c = 0; c < JH; c++) begin
                n_checks++;
                if ({pje, pcchange, pclocation, flush} !== {codes[i], offs[i], tgts[i], 1'b1}) begin
                    n_fail++;
                    $display("FAIL cf_hold_%0d_%0d: pje %0d off %h tgt %h flush %b, expected %0d %h %h 1",
                             i, c, pje, pcchange, pclocation, flush, codes[i], offs[i], tgts[i]);
                end
                fetchoutput = 32'h0A5B_0000;
                tick();
            end
            fetchoutput = 32'h0;
            n_checks++;
            if ({pje, flush, dec_valid} !== {3'd0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL cf_release_%0d: pje %0d flush %b valid %b, expected 0 0 0", i, pje, flush, dec_valid);
            end
            tick();
        end
    endtask

    task automatic test_long();
        prev_pc = 20'h00200;
`ifdef DECODE_32BIT_EN
        fetchoutput = 32'h8A5B_8D00;
        exp_q.push_back(model(fetchoutput, prev_pc));
        tick();
        n_checks++;
        if ({dec_valid, dec_len32, dec_rd} !== {1'b1, 1'b1, 6'h21}) begin
            n_fail++;
            $display("FAIL long_issue: v%b len32 %b rd %h, expected v1 len32 1 rd 21", dec_valid, dec_len32, dec_rd);
        end
        fetchoutput = 32'h0A5B_0000;
        tick();
        n_checks++;
        if ({dec_valid, illegal} !== 2'b00) begin n_fail++; $display("FAIL long_skip: valid/illegal got %b, expected 00", {dec_valid, illegal}); end
        fetchoutput = 32'h0;
        tick();
`else
        fetchoutput = 32'h8A5B_8D00;
        tick();
        n_checks++;
        if ({dec_valid, illegal} !== 2'b01) begin n_fail++; $display("FAIL long_disabled: valid/illegal got %b, expected 01", {dec_valid, illegal}); end
        fetchoutput = 32'h0;
        tick();
        n_checks++;
        if ({dec_valid, illegal} !== 2'b00) begin n_fail++; $display("FAIL long_disabled_pulse: valid/illegal got %b, expected 00", {dec_valid, illegal}); end
`endif
        fetchoutput = 32'h8A5B_0D00;
        tick();
        n_checks++;
        if ({dec_valid, illegal} !== 2'b01) begin n_fail++; $display("FAIL bad_second_half: valid/illegal got %b, expected 01", {dec_valid, illegal}); end
        fetchoutput = 32'h0;
        tick();
        n_checks++;
        if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse_width: got %b, expected 0", illegal); end
    endtask

    task automatic test_backpressure();
        prev_pc = 20'h00300;
        ex_ready = 1'b0;
        fetchoutput = 32'h0A5B_0000;
        exp_q.push_back(model(fetchoutput, prev_pc));
        tick();
        fetchoutput = 32'h1C2D_0000;
        prev_pc = 20'h00301;
        exp_q.push_back(model(fetchoutput, prev_pc));
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({fetch_enable, dec_valid, dec_op, dec_rd, dec_rb, dec_pc} !== {1'b0, 1'b1, 4'd5, 6'd1, 6'd3, 20'h00300}) begin
                n_fail++;
                $display("FAIL stall_%0d: fe %b v %b op %0d rd %0d rb %0d pc %h, expected 0 1 5 1 3 00300",
                         i, fetch_enable, dec_valid, dec_op, dec_rd, dec_rb, dec_pc);
            end
            if (i < 3) tick();
        end
        ex_ready = 1'b1;
        #1;
        n_checks++;
        if (fetch_enable !== 1'b1) begin n_fail++; $display("FAIL stall_release_fe: got %b, expected 1", fetch_enable); end
        tick();
        n_checks++;
        if ({dec_valid, dec_op} !== {1'b1, 4'd14}) begin n_fail++; $display("FAIL stall_next: v %b op %0d, expected 1 14", dec_valid, dec_op); end
        fetchoutput = 32'h0;
        tick();
        n_checks++;
        if ({dec_valid, fetch_enable} !== 2'b01) begin n_fail++; $display("FAIL stall_drain: v/fe got %b, expected 01", {dec_valid, fetch_enable}); end
    endtask

    task automatic test_simultaneous();
        prev_pc = 20'h00400;
        ex_ready = 1'b0;
        fetchoutput = 32'h0A5B_0000;
        exp_q.push_back(model(fetchoutput, prev_pc));
        tick();
        fetchoutput = 32'h4005_0000;
        tick();
        n_checks++;
        if ({pje, dec_valid, fetch_enable} !== {3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL cf_blocked: pje %0d v %b fe %b, expected 0 1 0", pje, dec_valid, fetch_enable);
        end
        ex_ready = 1'b1;
        tick();
        n_checks++;
        if ({pje, flush, dec_valid} !== {3'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL cf_same_edge: pje %0d flush %b v %b, expected 1 1 0", pje, flush, dec_valid);
        end
        fetchoutput = 32'h0;
        tick(JH);
        n_checks++;
        if (pje !== 3'd0) begin n_fail++; $display("FAIL cf_same_edge_end: pje got %0d, expected 0", pje); end
    endtask

    task automatic test_reset_abort();
        fetchoutput = 32'h4217_0000;
        tick();
        n_checks++;
        if (pje !== 3'd2) begin n_fail++; $display("FAIL abort_setup: pje got %0d, expected 2", pje); end
        reset_n = 1'b0;
        fetchoutput = 32'h0;
        tick();
        n_checks++;
        if ({pje, flush} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL abort_hold: pje %0d flush %b, expected 0 0", pje, flush); end
        reset_n = 1'b1;
        ex_ready = 1'b0;
        fetchoutput = 32'h0A5B_0000;
        tick();
        reset_n = 1'b0;
        fetchoutput = 32'h0;
        tick();
        n_checks++;
        if ({dec_valid, fetch_enable} !== 2'b01) begin n_fail++; $display("FAIL abort_stall: v/fe got %b, expected 01", {dec_valid, fetch_enable}); end
        ex_ready = 1'b1;
        reset_n = 1'b1;
        tick(2);
        n_checks++;
        if ({dec_valid, pje} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL abort_idle: v %b pje %0d, expected 0 0", dec_valid, pje); end
    endtask

    initial begin
        test_reset();
        test_bubbles();
        test_alu();
        test_back_to_back();
        test_control_flow();
        test_long();
        test_backpressure();
        test_simultaneous();
        test_reset_abort();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d bundles outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
